// File: rtl/board_frame_tx.sv
// board_frame_tx: reads a ROWSxCOLS board of 2-bit cell codes through a
// synchronous read port and streams it as a framed byte sequence
// (SOF, packed cell bytes, XOR checksum) over a valid/ready link.
module board_frame_tx #(
  parameter int         ROWS = 10,
  parameter int         COLS = 10,
  parameter logic [7:0] SOF  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       board_sel,
  output logic       rd_sel,
  output logic       rd_en,
  output logic [6:0] rd_addr,
  input  logic [1:0] rd_code,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  // Four cells per byte; the board size is expected to be a multiple of 4.
  localparam logic [4:0] BYTES = 5'(ROWS * COLS / 4);

  typedef enum logic [2:0] {IDLE, HDR, FETCH, SEND, CHK, DONE} state_t;

  state_t     state;
  logic [6:0] idx;       // first cell index of the byte being assembled
  logic [4:0] byte_cnt;  // data bytes already handed to the consumer
  logic [7:0] chk;       // running XOR of the data bytes
  logic [2:0] fcnt;      // cycle within the 5-cycle fetch window
  logic [5:0] cells_p1;  // first three captured cells of the current byte

  // First cell of the byte lands in the MSBs.
  function automatic logic [7:0] pack_byte(input logic [5:0] first3,
                                           input logic [1:0] last);
    return {first3, last};
  endfunction

  function automatic logic [7:0] next_chk(input logic [7:0] acc,
                                          input logic [7:0] b);
    return acc ^ b;
  endfunction

  // ---- stage p1: capture read data one cycle after each read strobe ----
  // Collect returning cell codes; fcnt=0 is the first read, so nothing returns yet.
  always_ff @(posedge clk) begin
    if (state == FETCH && fcnt != 3'd0) begin
      cells_p1 <= {cells_p1[3:0], rd_code};
    end
  end

  // ---- control FSM with registered outputs ----
  // Sequence header, cell fetch, byte send and checksum; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      rd_en    <= 1'b0;
      rd_addr  <= 7'd0;
      rd_sel   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      idx      <= 7'd0;
      byte_cnt <= 5'd0;
      chk      <= 8'h00;
      fcnt     <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rd_sel   <= board_sel;
            busy     <= 1'b1;
            idx      <= 7'd0;
            byte_cnt <= 5'd0;
            chk      <= 8'h00;
            tx_data  <= SOF;
            tx_valid <= 1'b1;
            state    <= HDR;
          end
        end
        HDR: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            rd_en    <= 1'b1;
            rd_addr  <= idx;
            fcnt     <= 3'd0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          fcnt <= fcnt + 3'd1;
          // Reads go out on fcnt 0..3; the last code returns at fcnt 4.
          if (fcnt < 3'd3) begin
            rd_addr <= rd_addr + 7'd1;
          end else begin
            rd_en <= 1'b0;
          end
          if (fcnt == 3'd4) begin
            tx_data  <= pack_byte(cells_p1, rd_code);
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            chk      <= next_chk(chk, tx_data);
            idx      <= idx + 7'd4;
            byte_cnt <= byte_cnt + 5'd1;
            if (byte_cnt == BYTES - 5'd1) begin
              tx_data  <= next_chk(chk, tx_data);
              tx_valid <= 1'b1;
              state    <= CHK;
            end else begin
              rd_en   <= 1'b1;
              rd_addr <= idx + 7'd4;
              fcnt    <= 3'd0;
              state   <= FETCH;
            end
          end
        end
        CHK: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_frame_tx.sv
// tb_board_frame_tx: randomized self-checking bench for board_frame_tx with a
// frame-level reference model built directly from the board contents.
module tb_board_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       board_sel = 1'b0;
  logic       rd_sel;
  logic       rd_en;
  logic [6:0] rd_addr;
  logic [1:0] rd_code;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;

  board_frame_tx #(.ROWS(10), .COLS(10), .SOF(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .board_sel(board_sel),
    .rd_sel(rd_sel), .rd_en(rd_en), .rd_addr(rd_addr), .rd_code(rd_code),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Two boards behind a synchronous read port (one cycle latency).
  logic [1:0] board [2][100];
  always @(posedge clk) if (rd_en) rd_code <= board[rd_sel][rd_addr];

  // Observation state (written only by the monitor / ready driver).
  int         cyc = 0;
  logic [7:0] got[$];
  int         addrs[$];
  int         done_cnt = 0, done_cyc = 0, viol = 0, sel_viol = 0;
  int         stall_cyc = 0, rd_cnt = 0;
  logic       done_busy = 1'b0;

  // Control from the test tasks.
  int   rdy_mode = 0;
  logic exp_sel = 1'b0;
  int   fbase = 0, abase = 0, dbase = 0, vbase = 0, svbase = 0, stbase = 0, rcbase = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: samples on the falling edge.
  initial begin
    logic       pw;
    logic [7:0] pd;
    pw = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pw = 1'b0;
      end else begin
        if (tx_valid && tx_ready) got.push_back(tx_data);
        if (rd_en) begin
          addrs.push_back(int'(rd_addr));
          rd_cnt++;
          if (rd_addr >= 7'd100 || tx_valid) viol++;
        end
        if (done) begin
          done_cnt++;
          done_cyc  = cyc;
          done_busy = busy;
        end
        if (busy && rd_sel !== exp_sel) sel_viol++;
        if (pw && (!tx_valid || tx_data !== pd)) viol++;
        if (tx_valid && !tx_ready) stall_cyc++;
        pw = tx_valid && !tx_ready;
        pd = tx_data;
      end
    end
  end

  // Consumer ready: 0 = always ready, 1 = random, 2 = 7-cycle stalls on bytes 0 and 10.
  initial begin
    int stall_left;
    int last_st;
    int n;
    stall_left = 0;
    last_st = -1;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      n = got.size() - fbase;
      if (rdy_mode == 0) tx_ready = 1'b1;
      else if (rdy_mode == 1) tx_ready = ($urandom_range(0, 2) != 0);
      else if (stall_left > 0) begin
        stall_left--;
        tx_ready = 1'b0;
      end else if (tx_valid && (n == 0 || n == 10) && n != last_st) begin
        last_st = n;
        stall_left = 6;
        tx_ready = 1'b0;
      end else tx_ready = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] data_byte(input int sel, input int b);
    return {board[sel][4*b], board[sel][4*b+1], board[sel][4*b+2], board[sel][4*b+3]};
  endfunction

  function automatic logic [7:0] model_byte(input int sel, input int i);
    logic [7:0] c;
    c = 8'h00;
    if (i == 0) return 8'hA5;
    if (i <= 25) return data_byte(sel, i - 1);
    for (int b = 0; b < 25; b++) c = c ^ data_byte(sel, b);
    return c;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    if (got.size() > fbase + i) return got[fbase + i];
    return 8'hxx;
  endfunction

  // Index of the first frame byte that differs from the model, -1 if none.
  function automatic int first_bad(input int sel);
    for (int i = 0; i < 27; i++) begin
      if (got.size() <= fbase + i) return i;
      if (got[fbase + i] !== model_byte(sel, i)) return i;
    end
    return -1;
  endfunction

  task automatic fill_board(input int sel, input bit rnd);
    for (int i = 0; i < 100; i++) board[sel][i] = rnd ? 2'($urandom) : 2'b00;
  endtask

  task automatic snap();
    fbase = got.size(); abase = addrs.size(); dbase = done_cnt; vbase = viol;
    svbase = sel_viol; stbase = stall_cyc; rcbase = rd_cnt;
  endtask

  // Pulse start, optionally re-pulse it mid-frame, and wait (bounded) for done.
  task automatic run_frame(input logic sel, input bit repulse, output int s);
    @(posedge clk); #2;
    snap();
    start = 1'b1; board_sel = sel; exp_sel = sel;
    @(negedge clk);
    s = cyc;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk); #2;
      start = repulse && (k == 3 || k == 50 || k == 152 || k == 153);
      board_sel = 1'($urandom);
      if (k > 153 && done_cnt > dbase) break;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    checks++; if (rd_addr !== 7'd0) begin failures++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    checks++; if (rd_sel !== 1'b0) begin failures++; $display("FAIL reset_rd_sel: got %b want 0", rd_sel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++; if ({tx_valid, busy, rd_en} !== 3'b000) begin failures++; $display("FAIL idle_hold: got %b want 000", {tx_valid, busy, rd_en}); end
  endtask

  task automatic test_all_zero();
    int s, bad;
    rdy_mode = 0;
    fill_board(0, 0);
    run_frame(1'b0, 0, s);
    bad = first_bad(0);
    checks++; if (bad !== -1) begin failures++; $display("FAIL zero_frame: byte %0d got %h want %h", bad, got_at(bad), model_byte(0, bad)); end
    checks++; if (got.size() - fbase !== 27) begin failures++; $display("FAIL zero_len: got %0d want 27", got.size() - fbase); end
    checks++; if (got_at(26) !== 8'h00) begin failures++; $display("FAIL zero_chk: got %h want 00", got_at(26)); end
    checks++; if (done_cnt - dbase !== 1) begin failures++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt - dbase); end
    checks++; if (done_cyc - s !== 153) begin failures++; $display("FAIL zero_done_time: got %0d want 153", done_cyc - s); end
    checks++; if (done_busy !== 1'b0) begin failures++; $display("FAIL zero_busy_at_done: got %b want 0", done_busy); end
    checks++; if (viol - vbase !== 0) begin failures++; $display("FAIL zero_protocol: got %0d want 0", viol - vbase); end
  endtask

  task automatic test_corner_cells();
    int s, bad, seq_bad;
    rdy_mode = 0;
    fill_board(0, 0);
    board[0][0] = 2'b01;
    board[0][99] = 2'b01;
    run_frame(1'b0, 0, s);
    bad = first_bad(0);
    checks++; if (bad !== -1) begin failures++; $display("FAIL corner_frame: byte %0d got %h want %h", bad, got_at(bad), model_byte(0, bad)); end
    checks++; if (got_at(1) !== 8'h40) begin failures++; $display("FAIL corner_byte1: got %h want 40", got_at(1)); end
    checks++; if (got_at(25) !== 8'h01) begin failures++; $display("FAIL corner_byte25: got %h want 01", got_at(25)); end
    checks++; if (got_at(26) !== 8'h41) begin failures++; $display("FAIL corner_chk: got %h want 41", got_at(26)); end
    checks++; if (addrs.size() - abase !== 100) begin failures++; $display("FAIL corner_read_count: got %0d want 100", addrs.size() - abase); end
    seq_bad = -1;
    for (int i = 0; i < 100 && abase + i < addrs.size(); i++)
      if (seq_bad == -1 && addrs[abase + i] != i) seq_bad = i;
    checks++; if (seq_bad !== -1) begin failures++; $display("FAIL corner_addr_seq: read %0d got addr %0d want %0d", seq_bad, addrs[abase + seq_bad], seq_bad); end
  endtask

  task automatic test_guest_board();
    int s, bad;
    rdy_mode = 0;
    fill_board(0, 1);
    board[0][4] = 2'b01;
    fill_board(1, 0);
    board[1][4] = 2'b11; board[1][5] = 2'b10; board[1][6] = 2'b01; board[1][7] = 2'b00;
    run_frame(1'b1, 0, s);
    bad = first_bad(1);
    checks++; if (bad !== -1) begin failures++; $display("FAIL guest_frame: byte %0d got %h want %h", bad, got_at(bad), model_byte(1, bad)); end
    checks++; if (got_at(2) !== 8'hE4) begin failures++; $display("FAIL guest_byte2: got %h want e4", got_at(2)); end
    checks++; if (got_at(26) !== 8'hE4) begin failures++; $display("FAIL guest_chk: got %h want e4", got_at(26)); end
    checks++; if (sel_viol - svbase !== 0) begin failures++; $display("FAIL guest_rd_sel: %0d cycles with rd_sel != 1", sel_viol - svbase); end
  endtask

  task automatic test_stall();
    int s, bad;
    rdy_mode = 2;
    fill_board(0, 1);
    run_frame(1'b0, 0, s);
    bad = first_bad(0);
    checks++; if (bad !== -1) begin failures++; $display("FAIL stall_frame: byte %0d got %h want %h", bad, got_at(bad), model_byte(0, bad)); end
    checks++; if (viol - vbase !== 0) begin failures++; $display("FAIL stall_stable: got %0d violations want 0", viol - vbase); end
    checks++; if (stall_cyc - stbase !== 14) begin failures++; $display("FAIL stall_cycles: got %0d want 14", stall_cyc - stbase); end
    checks++; if (rd_cnt - rcbase !== 100) begin failures++; $display("FAIL stall_reads: got %0d want 100", rd_cnt - rcbase); end
    checks++; if (done_cyc - s !== 167) begin failures++; $display("FAIL stall_done_time: got %0d want 167", done_cyc - s); end
    rdy_mode = 0;
  endtask

  task automatic test_random_ready();
    int s, bad;
    logic sel;
    sel = 1'($urandom);
    rdy_mode = 1;
    fill_board(0, 1);
    fill_board(1, 1);
    run_frame(sel, 0, s);
    bad = first_bad(int'(sel));
    checks++; if (bad !== -1) begin failures++; $display("FAIL rand_frame: byte %0d got %h want %h", bad, got_at(bad), model_byte(int'(sel), bad)); end
    checks++; if (viol - vbase !== 0) begin failures++; $display("FAIL rand_protocol: got %0d violations want 0", viol - vbase); end
    checks++; if (rd_cnt - rcbase !== 100) begin failures++; $display("FAIL rand_reads: got %0d want 100", rd_cnt - rcbase); end
    checks++; if (sel_viol - svbase !== 0) begin failures++; $display("FAIL rand_rd_sel: got %0d bad cycles want 0", sel_viol - svbase); end
    rdy_mode = 0;
  endtask

  task automatic test_repulse();
    int s, bad;
    rdy_mode = 0;
    fill_board(0, 1);
    run_frame(1'b0, 1, s);
    repeat (200) @(posedge clk);
    #2;
    bad = first_bad(0);
    checks++; if (bad !== -1) begin failures++; $display("FAIL repulse_frame: byte %0d got %h want %h", bad, got_at(bad), model_byte(0, bad)); end
    checks++; if (got.size() - fbase !== 27) begin failures++; $display("FAIL repulse_len: got %0d want 27", got.size() - fbase); end
    checks++; if (done_cnt - dbase !== 1) begin failures++; $display("FAIL repulse_done_cnt: got %0d want 1", done_cnt - dbase); end
    checks++; if (done_cyc - s !== 153) begin failures++; $display("FAIL repulse_done_time: got %0d want 153", done_cyc - s); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int s, bad;
    found = 0;
    rdy_mode = 0;
    fill_board(0, 1);
    @(posedge clk); #2;
    snap();
    start = 1'b1; board_sel = 1'b0; exp_sel = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (got.size() - fbase == 12 && tx_valid) begin
        found = 1;
        break;
      end
      @(posedge clk); #2;
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL rstmid_reach_byte12: got %b want 1", found); end
    rst = 1'b1;
    @(posedge clk); #2;
    checks++; if ({tx_valid, busy, rd_en, done} !== 4'b0000) begin failures++; $display("FAIL rstmid_outputs: got %b want 0000", {tx_valid, busy, rd_en, done}); end
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    checks++; if (done_cnt - dbase !== 0) begin failures++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - dbase); end
    checks++; if (got.size() - fbase !== 12) begin failures++; $display("FAIL rstmid_no_more_bytes: got %0d want 12", got.size() - fbase); end
    run_frame(1'b0, 0, s);
    bad = first_bad(0);
    checks++; if (bad !== -1) begin failures++; $display("FAIL rstmid_next_frame: byte %0d got %h want %h", bad, got_at(bad), model_byte(0, bad)); end
    checks++; if (done_cnt - dbase !== 1) begin failures++; $display("FAIL rstmid_next_done: got %0d want 1", done_cnt - dbase); end
  endtask

  initial begin
    fill_board(0, 0);
    fill_board(1, 0);
    test_reset();
    test_all_zero();
    test_corner_cells();
    test_guest_board();
    test_stall();
    test_random_ready();
    test_repulse();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_frame_tx.md
Name: board_frame_tx

Overview:
- Reads one 10x10 game board (2-bit cell codes) cell by cell through a synchronous read port.
- Packs 4 cells per byte and streams the board as a framed byte sequence over a valid/ready interface.
- The downstream consumer is the UART transmitter, which syncs the board to the opponent's Basys3.
- It is the read/transmit end of the board matrix that the placement/shot logic writes.

Parameters:
- ROWS, 10, board rows.
- COLS, 10, board columns.
- SOF, 8'hA5, start-of-frame header byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to send a frame; ignored while busy=1.
- board_sel  in  1  0 = host board, 1 = guest board; latched on accepted start.
- rd_sel  out  1  latched board_sel, driven to the board read mux.
- rd_en  out  1  cell read strobe.
- rd_addr  out  7  linear cell index, row*COLS+col, range 0..99.
- rd_code  in  2  cell code, valid exactly 1 cycle after rd_en (00 empty, 01 ship, 10 hit, 11 miss).
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  consumer accepts the byte when tx_valid & tx_ready.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the checksum byte is accepted.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - All outputs go to 0: tx_valid, tx_data, rd_en, rd_addr, rd_sel, busy, done.
  - The FSM goes to IDLE.
  - Cell index, byte counter and checksum are cleared.
- Reset mid-frame aborts with no further bytes and no done pulse.
- Frame is 27 bytes:
  - SOF.
  - 25 data bytes.
  - XOR checksum of the 25 data bytes (SOF excluded).
- Packing: data byte b = {cell 4b, cell 4b+1, cell 4b+2, cell 4b+3}, so the first cell sits in bits [7:6].
- FSM states: IDLE, HDR, FETCH, SEND, CHK, DONE.
- IDLE:
  - On start=1, latch board_sel into rd_sel, set busy=1, clear cell index and checksum, go to HDR.
  - Otherwise hold.
- HDR:
  - tx_data=SOF and tx_valid=1 from the cycle after start was accepted.
  - Hold both until tx_ready=1, then go to FETCH.
- FETCH:
  - Issue 4 consecutive reads: rd_en=1 with rd_addr = idx, idx+1, idx+2, idx+3 on 4 consecutive cycles.
  - Capture rd_code into the shift register 1 cycle after each read.
  - After the 4th capture (5 cycles in FETCH), go to SEND. tx_valid=0 throughout FETCH.
  - rd_en=0 in every other state.
  - rd_addr holds its last value when rd_en=0.
- SEND:
  - tx_valid=1 with the packed byte; hold data stable while tx_ready=0.
  - On handshake: checksum ^= byte, idx += 4.
  - If idx reaches 100, go to CHK; otherwise go to FETCH.
- CHK: tx_data=checksum and tx_valid=1 until the handshake, then go to DONE.
- DONE: done=1 for one cycle; busy goes to 0 in the same cycle; next state IDLE.
- tx_ready arriving when tx_valid=0 has no effect.
- tx_valid never drops before the handshake.
- start while busy=1 is ignored; start is not queued.
- start in the DONE cycle is ignored; a new start is accepted from IDLE only.
- board_sel changes during a frame have no effect (rd_sel is latched).
- Minimum frame duration with tx_ready tied to 1: 1 (HDR) + 25*(5+1) + 1 (CHK) + 1 (DONE) = 153 cycles after start.
- Widths:
  - idx is 7 bits and never exceeds 100.
  - Byte counter reaches 25 exactly.
  - The last read address is 99; addresses >= 100 are never issued.

Test Plan:
- All-zero board, tx_ready=1, start pulse -> bytes A5, then 25 x 00, then checksum 00; done pulses at start+153 cycles; busy falls on the same cycle.
- Cell 0 = 01, cell 99 = 01, rest 00 -> byte1=0x40, byte25=0x01, checksum=0x41; rd_addr sequence is 0..99 with no gaps or repeats.
- Cells 4..7 = 11,10,01,00 with board_sel=1 -> rd_sel=1 for the whole frame, byte2=0xE4, checksum=0xE4.
- tx_ready low for 7 cycles on the SOF byte and on data byte 10 -> tx_valid and tx_data stay stable; no extra rd_en issued; frame content unchanged vs. the ready=1 run.
- start re-pulsed at cycles 3, 50 and 152 of a frame -> ignored; exactly one 27-byte frame and one done pulse.
- rst=1 during SEND of byte 12 -> next cycle tx_valid=0, busy=0, rd_en=0, no done; a subsequent start sends a full frame beginning with A5.
